// File: rtl/sar_conv_sched.sv
// Round-robin scheduler sharing one SAR ADC digital back end among several requesters,
// with an end-of-conversion watchdog that recovers a hung back end through its reset.
module sar_conv_sched #(
    parameter int ADC_RESOLUTION = 10,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RST_CYCLES     = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic                       o_busy,
    output logic                       o_start,
    output logic                       o_dbe_rstn,
    input  logic                       i_eoc,
    input  logic [ADC_RESOLUTION-1:0]  i_a2d,
    output logic [ADC_RESOLUTION-1:0]  o_data,
    output logic                       o_data_vld,
    output logic [$clog2(NUM_REQ)-1:0] o_data_id,
    output logic                       o_timeout
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RCW = $clog2(RST_CYCLES) + 1;
    localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [RCW-1:0] RCNT_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_RECOVER,
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t                    state, state_nxt;
    logic [IDW-1:0]            rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]            winner, winner_nxt;
    logic [WDW-1:0]            wdog, wdog_nxt, wdog_inc;
    logic [RCW-1:0]            rcnt, rcnt_nxt;
    logic                      eoc_prev, eoc_edge;

    logic [IDW-1:0]            cand;
    logic [IDW-1:0]            pick;
    logic                      any_req;
    logic [NUM_REQ-1:0]        pick_onehot;
    logic [IDW-1:0]            ptr_after;

    logic [NUM_REQ-1:0]        gnt_nxt;
    logic                      busy_nxt;
    logic                      start_nxt;
    logic                      dbe_rstn_nxt;
    logic [ADC_RESOLUTION-1:0] data_nxt;
    logic                      data_vld_nxt;
    logic [IDW-1:0]            data_id_nxt;
    logic                      timeout_nxt;

    // Walk downward so the candidate closest above the pointer is the one left standing.
    always_comb begin
        cand    = '0;
        pick    = '0;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (i_req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_onehot[i] = (IDW'(i) == pick);
        end
    end

    assign ptr_after = (winner == LAST_ID) ? '0 : winner + IDW'(1);
    assign eoc_edge  = i_eoc & ~eoc_prev;
    assign wdog_inc  = wdog + WDW'(1);

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        winner_nxt   = winner;
        wdog_nxt     = wdog;
        rcnt_nxt     = rcnt;
        gnt_nxt      = o_gnt;
        start_nxt    = 1'b0;
        dbe_rstn_nxt = o_dbe_rstn;
        data_nxt     = o_data;
        data_vld_nxt = 1'b0;
        data_id_nxt  = o_data_id;
        timeout_nxt  = 1'b0;

        case (state)
            S_RECOVER: begin
                dbe_rstn_nxt = 1'b0;
                if (rcnt == RCNT_LAST) begin
                    rcnt_nxt     = '0;
                    dbe_rstn_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end else begin
                    rcnt_nxt = rcnt + RCW'(1);
                end
            end
            S_IDLE: begin
                if (any_req) begin
                    winner_nxt = pick;
                    gnt_nxt    = pick_onehot;
                    start_nxt  = 1'b1;
                    state_nxt  = S_START;
                end
            end
            S_START: begin
                wdog_nxt  = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // The threshold is tested on the incremented count; an eoc edge in that cycle still wins.
                wdog_nxt = wdog_inc;
                if (eoc_edge) begin
                    data_nxt     = i_a2d;
                    data_id_nxt  = winner;
                    data_vld_nxt = 1'b1;
                    gnt_nxt      = '0;
                    rr_ptr_nxt   = ptr_after;
                    state_nxt    = S_IDLE;
                end else if (wdog_inc == WDOG_LIMIT) begin
                    timeout_nxt  = 1'b1;
                    gnt_nxt      = '0;
                    rr_ptr_nxt   = ptr_after;
                    dbe_rstn_nxt = 1'b0;
                    rcnt_nxt     = '0;
                    state_nxt    = S_RECOVER;
                end
            end
            default: begin
                state_nxt = S_RECOVER;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // eoc history tracks the pin in every state, so an eoc still high from the last
    // conversion cannot look like a fresh edge when WAIT begins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_RECOVER;
            rr_ptr     <= '0;
            winner     <= '0;
            wdog       <= '0;
            rcnt       <= '0;
            eoc_prev   <= 1'b0;
            o_gnt      <= '0;
            o_busy     <= 1'b1;
            o_start    <= 1'b0;
            o_dbe_rstn <= 1'b0;
            o_data     <= '0;
            o_data_vld <= 1'b0;
            o_data_id  <= '0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            winner     <= winner_nxt;
            wdog       <= wdog_nxt;
            rcnt       <= rcnt_nxt;
            eoc_prev   <= i_eoc;
            o_gnt      <= gnt_nxt;
            o_busy     <= busy_nxt;
            o_start    <= start_nxt;
            o_dbe_rstn <= dbe_rstn_nxt;
            o_data     <= data_nxt;
            o_data_vld <= data_vld_nxt;
            o_data_id  <= data_id_nxt;
            o_timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_sar_conv_sched.sv
// Directed bench for sar_conv_sched: a scripted back-end model drives eoc/code and a
// scoreboard queue holds the expected (id, code) of every result strobe.
module tb_sar_conv_sched;

    localparam int AW  = 10;
    localparam int NR  = 4;
    localparam int TO  = 64;
    localparam int RSC = 3;

    logic          clk = 1'b0;
    logic          i_rst;
    logic [NR-1:0] i_req;
    logic [NR-1:0] o_gnt;
    logic          o_busy;
    logic          o_start;
    logic          o_dbe_rstn;
    logic          i_eoc;
    logic [AW-1:0] i_a2d;
    logic [AW-1:0] o_data;
    logic          o_data_vld;
    logic [1:0]    o_data_id;
    logic          o_timeout;

    typedef struct {
        int            id;
        logic [AW-1:0] code;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_ptr = 0;

    sar_conv_sched #(
        .ADC_RESOLUTION(AW),
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(TO),
        .RST_CYCLES    (RSC)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .o_gnt     (o_gnt),
        .o_busy    (o_busy),
        .o_start   (o_start),
        .o_dbe_rstn(o_dbe_rstn),
        .i_eoc     (i_eoc),
        .i_a2d     (i_a2d),
        .o_data    (o_data),
        .o_data_vld(o_data_vld),
        .o_data_id (o_data_id),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] req, input int ptr);
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (ptr + i) % NR;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic check_reset_values();
        check("rst_gnt",      32'(o_gnt),      32'd0);
        check("rst_start",    32'(o_start),    32'd0);
        check("rst_data",     32'(o_data),     32'd0);
        check("rst_data_vld", 32'(o_data_vld), 32'd0);
        check("rst_data_id",  32'(o_data_id),  32'd0);
        check("rst_timeout",  32'(o_timeout),  32'd0);
        check("rst_dbe_rstn", 32'(o_dbe_rstn), 32'd0);
        check("rst_busy",     32'(o_busy),     32'd1);
    endtask

    // Called in the first cycle of RECOVER; back end must stay in reset RSC cycles.
    task automatic check_recovery();
        for (int c = 0; c < RSC; c++) begin
            check("rec_dbe_rstn_low", 32'(o_dbe_rstn), 32'd0);
            check("rec_busy",         32'(o_busy),     32'd1);
            check("rec_no_start",     32'(o_start),    32'd0);
            if (c > 0) check("rec_timeout_once", 32'(o_timeout), 32'd0);
            step(1);
        end
        check("rec_dbe_rstn_high", 32'(o_dbe_rstn), 32'd1);
        check("rec_idle",          32'(o_busy),     32'd0);
    endtask

    // One full conversion: eoc rises d cycles after the start cycle (low the cycle before).
    task automatic run_conv(input logic [NR-1:0] req, input logic [NR-1:0] req_after,
                            input int d, input logic [AW-1:0] code,
                            input bit hold_eoc, input bit drop_mid);
        int id;
        id = rr_pick(req, model_ptr);
        check("idle_before_req", 32'(o_busy), 32'd0);
        i_req = req;
        step(1);
        check("start_pulse", 32'(o_start), 32'd1);
        check("grant",       32'(o_gnt),   32'd1 << id);
        check("busy",        32'(o_busy),  32'd1);
        step(1);
        check("start_one_cycle", 32'(o_start), 32'd0);
        check("grant_held",      32'(o_gnt),   32'd1 << id);
        if (drop_mid) i_req = '0;
        step(d - 2);
        i_eoc = 1'b0;
        step(1);
        i_eoc = 1'b1;
        i_a2d = code;
        sb.push_back('{id, code});
        step(1);
        check("vld_latency",  32'(o_data_vld), 32'd1);
        check("gnt_released", 32'(o_gnt),      32'd0);
        check("idle_gap",     32'(o_start),    32'd0);
        check("no_timeout",   32'(o_timeout),  32'd0);
        if (!hold_eoc) i_eoc = 1'b0;
        i_req = req_after;
        model_ptr = (id + 1) % NR;
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("gnt_onehot0", 32'($onehot0(o_gnt)), 32'd1);
        if (o_data_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_vld", 32'(o_data_vld), 32'd0);
            end else begin
                e = sb.pop_front();
                check("data",    32'(o_data),    32'(e.code));
                check("data_id", 32'(o_data_id), 32'(e.id));
            end
        end
    end

    initial begin
        int id;
        i_rst = 1'b1;
        i_req = '0;
        i_eoc = 1'b0;
        i_a2d = '0;

        $display("[TB] reset hold and recovery");
        step(2);
        check_reset_values();
        i_rst = 1'b0;
        check_recovery();

        $display("[TB] single requester 2, code 2A5");
        run_conv(4'b0100, 4'b0000, 12, 10'h2A5, 1'b0, 1'b0);
        run_conv(4'b1001, 4'b1111, 6, 10'h155, 1'b0, 1'b0);

        $display("[TB] all requesters held");
        for (int k = 0; k < 5; k++) begin
            run_conv(4'b1111, (k == 4) ? 4'b0000 : 4'b1111, 5 + k,
                     10'(rr_pick(4'b1111, model_ptr)), 1'b0, 1'b0);
        end

        $display("[TB] watchdog timeout");
        id = rr_pick(4'b0010, model_ptr);
        i_req = 4'b0010;
        step(1);
        check("to_start", 32'(o_start), 32'd1);
        check("to_grant", 32'(o_gnt),   32'd1 << id);
        step(TO - 1);
        check("to_not_early", 32'(o_timeout), 32'd0);
        check("to_busy",      32'(o_busy),    32'd1);
        step(1);
        check("to_pulse",    32'(o_timeout), 32'd1);
        check("to_gnt_zero", 32'(o_gnt),     32'd0);
        model_ptr = (id + 1) % NR;
        i_req = 4'b0110;
        check_recovery();
        run_conv(4'b0110, 4'b0001, 10, 10'h2C7, 1'b1, 1'b0);

        $display("[TB] eoc held high across a new start");
        run_conv(4'b0001, 4'b0000, 8, 10'h3C3, 1'b0, 1'b0);

        $display("[TB] request dropped during WAIT");
        run_conv(4'b0100, 4'b0000, 9, 10'h0F0, 1'b0, 1'b1);

        $display("[TB] reset during WAIT");
        id = rr_pick(4'b1000, model_ptr);
        i_req = 4'b1000;
        step(1);
        check("mr_start", 32'(o_start), 32'd1);
        check("mr_grant", 32'(o_gnt),   32'd1 << id);
        step(4);
        i_rst = 1'b1;
        step(1);
        check_reset_values();
        step(1);
        i_req = '0;
        i_rst = 1'b0;
        model_ptr = 0;
        check_recovery();
        run_conv(4'b1010, 4'b0000, 5, 10'h001, 1'b0, 1'b0);

        step(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
